// File: rtl/display_pkg.sv
// Shared definitions for the two-digit 7-segment display controller:
// active-low segment patterns, the blank/show state type and the decoder.
package display_pkg;

    // Active-low segment patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_0       = 7'b1000000;
    localparam logic [6:0] SEG_1       = 7'b1111001;
    localparam logic [6:0] SEG_2       = 7'b0100100;
    localparam logic [6:0] SEG_3       = 7'b0110000;
    localparam logic [6:0] SEG_4       = 7'b0011001;
    localparam logic [6:0] SEG_5       = 7'b0010010;
    localparam logic [6:0] SEG_6       = 7'b0000010;
    localparam logic [6:0] SEG_7       = 7'b1111000;
    localparam logic [6:0] SEG_8       = 7'b0000000;
    localparam logic [6:0] SEG_9       = 7'b0010000;
    localparam logic [6:0] SEG_GUION   = 7'b0111111;
    localparam logic [6:0] SEG_APAGADO = 7'b1111111;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } estado_t;

    // Non-decimal codes show a dash so a bad upstream value is visible.
    function automatic logic [6:0] decodificar_7seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_GUION;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_display_generador_refresco.sv
// Refresh generator: free-running divider that pulses tick on its last
// count and toggles the position select on that same edge.
module generador_refresco #(
    parameter int DIV   = 10,
    parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             tick_o,
    output logic             sel_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    generate
        if (DIV < 4) begin : g_div_check
            $error("generador_refresco: DIV must be >= 4");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             tick;

    assign tick = (cnt_q == CNT_MAX);

    // Next divider count and select: wrap and toggle on the tick.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        sel_d = sel_q;
        if (tick) begin
            cnt_d = '0;
            sel_d = ~sel_q;
        end
    end

    // Divider and select registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sel_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

    assign tick_o = tick;
    assign sel_o  = sel_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/control_display.sv
// Two-position 7-segment display multiplexer. Alternates units/tens every
// DIV cycles, keeps everything dark for BLANK_CYC cycles after each switch
// to avoid ghosting, then latches the digit and lights one anode.
module control_display
    import display_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 100_000_000,
    parameter int REFRESH_HZ    = 10_000,
    parameter int BLANK_CYC     = 16,
    parameter int N_ANODOS      = 8,
    parameter int SUPRIMIR_CERO = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          digito,
    output logic                contador_actualizar,
    output logic [N_ANODOS-1:0] anodo,
    output logic [6:0]          segmentos,
    output logic                punto
);

    localparam int DIV   = CLK_FREQ_HZ / REFRESH_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_CAPTURA = CNT_W'(BLANK_CYC - 1);

    generate
        if (DIV < 4) begin : g_div_check
            $error("control_display: CLK_FREQ_HZ/REFRESH_HZ must be >= 4");
        end
        if (BLANK_CYC < 1 || BLANK_CYC >= DIV) begin : g_blank_check
            $error("control_display: need 1 <= BLANK_CYC < DIV");
        end
        if (N_ANODOS < 2) begin : g_anodo_check
            $error("control_display: N_ANODOS must be >= 2");
        end
    endgenerate

    logic             tick;
    logic             sel;
    logic [CNT_W-1:0] cnt;

    generador_refresco #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_refresco (
        .clk_i  (clk),
        .rst_i  (rst),
        .tick_o (tick),
        .sel_o  (sel),
        .cnt_o  (cnt)
    );

    estado_t               estado_q;
    logic [3:0]            dig_q;
    logic [N_ANODOS-1:0]   anodo_q;
    logic [6:0]            seg_q;

    logic                  captura;
    logic                  apagar_decenas;
    logic [N_ANODOS-1:0]   anodo_show;

    // Capture point is the last dark cycle of the blanking window.
    assign captura        = (estado_q == BLANK) && (cnt == CNT_CAPTURA);
    assign apagar_decenas = (SUPRIMIR_CERO != 0) && sel && (digito == 4'd0);

    // Anode pattern to load at capture: only the selected position goes low.
    always_comb begin
        anodo_show = '1;
        if (!apagar_decenas) begin
            if (sel) begin
                anodo_show[1] = 1'b0;
            end else begin
                anodo_show[0] = 1'b0;
            end
        end
    end

    // Blank/show FSM with registered anode and segment outputs; the tick
    // is checked first so a switch always wins over a capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= BLANK;
            dig_q    <= 4'd0;
            anodo_q  <= '1;
            seg_q    <= SEG_APAGADO;
        end else if (tick) begin
            estado_q <= BLANK;
            anodo_q  <= '1;
            seg_q    <= SEG_APAGADO;
        end else if (captura) begin
            estado_q <= SHOW;
            dig_q    <= digito;
            anodo_q  <= anodo_show;
            seg_q    <= decodificar_7seg(digito);
        end else if (estado_q == SHOW) begin
            seg_q    <= decodificar_7seg(dig_q);
        end
    end

    assign contador_actualizar = sel;
    assign anodo               = anodo_q;
    assign segmentos           = seg_q;
    assign punto               = 1'b1;

endmodule

// File: tb/tb_control_display.sv
// Bench for control_display with DIV=10, BLANK_CYC=2. The reference model
// derives outputs from the cycle index since reset and the digit presented
// at each capture point.
module tb_control_display;

    localparam int DIV = 10;
    localparam int BLK = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] digito = 4'd0;
    logic       contador_actualizar;
    logic [7:0] anodo;
    logic [6:0] segmentos;
    logic       punto;

    always #5 clk = ~clk;

    control_display #(
        .CLK_FREQ_HZ   (1000),
        .REFRESH_HZ    (100),
        .BLANK_CYC     (BLK),
        .N_ANODOS      (8),
        .SUPRIMIR_CERO (1)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .digito              (digito),
        .contador_actualizar (contador_actualizar),
        .anodo               (anodo),
        .segmentos           (segmentos),
        .punto               (punto)
    );

    int         total = 0;
    int         bad   = 0;
    int         t     = 0;     // cycles since reset release
    logic [3:0] cap   = 4'd0;  // digit presented at the latest capture point
    int         mode  = 0;     // 0: selector from bin_v, 1: forced, 2: random
    int         bin_v = 13;
    logic [3:0] force_val = 4'd0;
    logic [6:0] dec [16];
    logic [16:0] exp_v;

    initial begin
        dec[0] = 7'b1000000; dec[1] = 7'b1111001; dec[2] = 7'b0100100;
        dec[3] = 7'b0110000; dec[4] = 7'b0011001; dec[5] = 7'b0010010;
        dec[6] = 7'b0000010; dec[7] = 7'b1111000; dec[8] = 7'b0000000;
        dec[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) dec[i] = 7'b0111111;
    end

    // Expected {anodo, segmentos, contador_actualizar, punto} at cycle t.
    function automatic logic [16:0] model_out();
        int pos = t % DIV;
        int ph  = (t / DIV) % 2;
        logic [7:0] an;
        logic [6:0] sg;
        if (pos < BLK) begin
            an = 8'hFF;
            sg = 7'h7F;
        end else begin
            sg = dec[cap];
            if (ph == 0)       an = 8'hFE;
            else if (cap == 0) an = 8'hFF;
            else               an = 8'hFD;
        end
        return {an, sg, ph[0], 1'b1};
    endfunction

    // Present the selector's digit for this cycle, then move to the next one.
    task automatic advance();
        int ph = (t / DIV) % 2;
        logic [3:0] d;
        case (mode)
            0:       d = (ph == 1) ? 4'((bin_v / 10) % 10) : 4'(bin_v % 10);
            1:       d = force_val;
            default: d = 4'($urandom_range(0, 15));
        endcase
        digito = d;
        if (t % DIV == BLK - 1) cap = d;
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({anodo, segmentos, contador_actualizar, punto} !== {8'hFF, 7'h7F, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_hold got an=%h seg=%b sel=%b dp=%b expected an=ff seg=1111111 sel=0 dp=1",
                     anodo, segmentos, contador_actualizar, punto);
        end
        rst = 1'b0;
        t = 0;
        mode = 0;
        bin_v = 13;
        repeat (3) begin
            exp_v = model_out();
            total++;
            if ({anodo, segmentos, contador_actualizar, punto} !== exp_v) begin
                bad++;
                $display("FAIL reset_release t=%0d got=%h expected=%h", t, {anodo, segmentos, contador_actualizar, punto}, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_bin13();
        mode = 0;
        bin_v = 13;
        repeat (40) begin
            exp_v = model_out();
            total++;
            if ({anodo, segmentos, contador_actualizar, punto} !== exp_v) begin
                bad++;
                $display("FAIL bin13 t=%0d got=%h expected=%h", t, {anodo, segmentos, contador_actualizar, punto}, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_zero_suppress();
        mode = 0;
        bin_v = 7;
        repeat (40) begin
            exp_v = model_out();
            total++;
            if ({anodo, segmentos, contador_actualizar, punto} !== exp_v) begin
                bad++;
                $display("FAIL zero_suppress t=%0d got=%h expected=%h", t, {anodo, segmentos, contador_actualizar, punto}, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_hold_mid_show();
        mode = 0;
        while (t % (2 * DIV) != 0) advance();
        mode = 1;
        force_val = 4'd3;
        repeat (30) begin
            if (t % (2 * DIV) == 4) force_val = 4'd8;
            exp_v = model_out();
            total++;
            if ({anodo, segmentos, contador_actualizar, punto} !== exp_v) begin
                bad++;
                $display("FAIL hold_mid_show t=%0d got=%h expected=%h", t, {anodo, segmentos, contador_actualizar, punto}, exp_v);
            end
            if (t < 2 * DIV && t % DIV >= BLK && t % (2 * DIV) < DIV) begin
                total++;
                if (segmentos !== 7'b0110000) begin
                    bad++;
                    $display("FAIL hold_frozen t=%0d got seg=%b expected seg=0110000", t, segmentos);
                end
            end
            advance();
        end
    endtask

    task automatic test_dash();
        mode = 1;
        force_val = 4'd12;
        repeat (20) advance();
        repeat (20) begin
            exp_v = model_out();
            total++;
            if ({anodo, segmentos, contador_actualizar, punto} !== exp_v) begin
                bad++;
                $display("FAIL dash t=%0d got=%h expected=%h", t, {anodo, segmentos, contador_actualizar, punto}, exp_v);
            end
            if (t % DIV >= BLK) begin
                total++;
                if (segmentos !== 7'b0111111) begin
                    bad++;
                    $display("FAIL dash_seg t=%0d got seg=%b expected seg=0111111", t, segmentos);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_show();
        mode = 0;
        bin_v = 13;
        while (t % (2 * DIV) != 15) advance();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        t = 0;
        total++;
        if ({anodo, segmentos, contador_actualizar} !== {8'hFF, 7'h7F, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_show got an=%h seg=%b sel=%b expected an=ff seg=1111111 sel=0",
                     anodo, segmentos, contador_actualizar);
        end
        repeat (15) begin
            exp_v = model_out();
            total++;
            if ({anodo, segmentos, contador_actualizar, punto} !== exp_v) begin
                bad++;
                $display("FAIL after_reset t=%0d got=%h expected=%h", t, {anodo, segmentos, contador_actualizar, punto}, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_random();
        repeat (400) begin
            if ($urandom_range(0, 29) == 0) mode = $urandom_range(0, 2);
            if ($urandom_range(0, 19) == 0) bin_v = $urandom_range(0, 99);
            if ($urandom_range(0, 9) == 0) force_val = 4'($urandom_range(0, 15));
            exp_v = model_out();
            total++;
            if ({anodo, segmentos, contador_actualizar, punto} !== exp_v) begin
                bad++;
                $display("FAIL random t=%0d got=%h expected=%h", t, {anodo, segmentos, contador_actualizar, punto}, exp_v);
            end
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                advance();
                rst = 1'b0;
                t = 0;
            end else begin
                advance();
            end
        end
    endtask

    initial begin
        test_reset();
        test_bin13();
        test_zero_suppress();
        test_hold_mid_show();
        test_dash();
        test_reset_mid_show();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
